opb_reg_slave: RTL and testbench

OPB target register bank sitting directly downstream of the OPB emulation master in the UART test firmware; it decodes `OPB_ADDR`, `OPB_RE`, `OPB_WE` and `OPB_DO` from the master and returns read data on `OPB_DI`. It provides the fixed ID, scratch, control and status registers, a 2 kHz tick counter and a 32-bit loopback FIFO, so the UART-to-OPB path can be exercised end to end without the real DMD logic.

---
 rtl/opb_reg_slave.sv | 124 ++++++++++++
 tb/tb_opb_reg_slave.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/opb_reg_slave.sv
// OPB target register bank: ID, scratch, control/status, 2 kHz tick counter,
// access counters and a 32-bit loopback FIFO for exercising the UART-to-OPB path.
module opb_reg_slave #(
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
  parameter logic [31:0] ID_VALUE   = 32'h0106_0973,
  parameter int          FIFO_DEPTH = 16
) (
  input  logic        OPB_CLK,
  input  logic        OPB_RST,
  input  logic        PULSE_2KHZ,
  input  logic [31:0] OPB_ADDR,
  input  logic [31:0] OPB_DO,
  input  logic        OPB_RE,
  input  logic        OPB_WE,
  output logic [31:0] OPB_DI,
  output logic        FIFO_NEMPTY
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] DEPTH_L = LW'(FIFO_DEPTH);

  logic [31:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [LW-1:0] level, nxt_level;
  logic          ovf, tick_en, pulse_q;
  logic [31:0]   scratch, tick_cnt, wr_cnt, rd_cnt;

  logic          hit, wr_en, rd_en, oow_rd;
  logic [7:0]    off;
  logic          full, empty, push, pop, fifo_clr, cnt_clr, ovf_clr, tick_edge;
  logic [31:0]   rd_data, status;

  assign hit    = (OPB_ADDR[31:8] == BASE_ADDR[31:8]);
  assign off    = {OPB_ADDR[7:2], 2'b00};
  assign wr_en  = OPB_WE & hit;
  // A write in the same cycle as a read suppresses the read entirely.
  assign rd_en  = OPB_RE & ~OPB_WE & hit;
  assign oow_rd = OPB_RE & ~OPB_WE & ~hit;

  assign full      = (level == DEPTH_L);
  assign empty     = (level == '0);
  assign push      = wr_en && (off == 8'h14);
  assign pop       = rd_en && (off == 8'h14) && !empty;
  assign fifo_clr  = wr_en && (off == 8'h08) && OPB_DO[1];
  assign cnt_clr   = wr_en && (off == 8'h08) && OPB_DO[2];
  assign ovf_clr   = wr_en && (off == 8'h0C) && OPB_DO[2];
  assign tick_edge = PULSE_2KHZ & ~pulse_q;

  assign status = {15'b0, 9'(level), 5'b0, ovf, full, empty};

  // Next FIFO level; a clear overrides any access
  always_comb begin
    nxt_level = level;
    if (fifo_clr)          nxt_level = '0;
    else if (push && !full) nxt_level = level + 1'b1;
    else if (pop)          nxt_level = level - 1'b1;
  end

  // Read data mux for in-window offsets
  always_comb begin
    rd_data = 32'hDEAD_BEEF;
    case (off)
      8'h00: rd_data = ID_VALUE;
      8'h04: rd_data = scratch;
      8'h08: rd_data = {31'b0, tick_en};
      8'h0C: rd_data = status;
      8'h10: rd_data = tick_cnt;
      8'h14: rd_data = empty ? 32'h0 : mem[rd_ptr];
      8'h18: rd_data = wr_cnt;
      8'h1C: rd_data = rd_cnt;
      default: rd_data = 32'hDEAD_BEEF;
    endcase
  end

  // FIFO storage, pointer-addressed, deliberately not reset
  always_ff @(posedge OPB_CLK) begin
    if (OPB_RST && push && !full) mem[wr_ptr] <= OPB_DO;
  end

  // Registers, counters, FIFO control and read data
  always_ff @(posedge OPB_CLK) begin
    if (!OPB_RST) begin
      OPB_DI      <= '0;
      FIFO_NEMPTY <= 1'b0;
      scratch     <= '0;
      tick_en     <= 1'b1;
      pulse_q     <= 1'b1;
      tick_cnt    <= '0;
      wr_cnt      <= '0;
      rd_cnt      <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      level       <= '0;
      ovf         <= 1'b0;
    end else begin
      pulse_q     <= PULSE_2KHZ;
      level       <= nxt_level;
      FIFO_NEMPTY <= (nxt_level != '0);

      if (rd_en)       OPB_DI <= rd_data;
      else if (oow_rd) OPB_DI <= '0;

      if (wr_en) wr_cnt <= wr_cnt + 1'b1;
      if (rd_en) rd_cnt <= rd_cnt + 1'b1;

      if (wr_en && off == 8'h04) scratch <= OPB_DO;
      if (wr_en && off == 8'h08) tick_en <= OPB_DO[0];

      if (cnt_clr)                   tick_cnt <= '0;
      else if (tick_edge && tick_en) tick_cnt <= tick_cnt + 1'b1;

      if (fifo_clr) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push && !full) wr_ptr <= wr_ptr + 1'b1;
        if (pop)           rd_ptr <= rd_ptr + 1'b1;
      end

      if (push && full) ovf <= 1'b1;
      else if (ovf_clr) ovf <= 1'b0;
    end
  end
endmodule

// File: tb/tb_opb_reg_slave.sv
// Directed bench for opb_reg_slave: one task per feature, inline checks.
module tb_opb_reg_slave;
  logic        OPB_CLK = 1'b0;
  logic        OPB_RST = 1'b0;
  logic        PULSE_2KHZ = 1'b0;
  logic [31:0] OPB_ADDR = '0;
  logic [31:0] OPB_DO = '0;
  logic        OPB_RE = 1'b0;
  logic        OPB_WE = 1'b0;
  logic [31:0] OPB_DI;
  logic        FIFO_NEMPTY;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_wr   = 0;
  int exp_rd   = 0;

  opb_reg_slave dut (
    .OPB_CLK(OPB_CLK), .OPB_RST(OPB_RST), .PULSE_2KHZ(PULSE_2KHZ),
    .OPB_ADDR(OPB_ADDR), .OPB_DO(OPB_DO), .OPB_RE(OPB_RE), .OPB_WE(OPB_WE),
    .OPB_DI(OPB_DI), .FIFO_NEMPTY(FIFO_NEMPTY)
  );

  always #5 OPB_CLK = ~OPB_CLK;

  task automatic opb_write(input logic [31:0] a, input logic [31:0] d);
    @(negedge OPB_CLK);
    OPB_ADDR = a; OPB_DO = d; OPB_WE = 1'b1;
    @(posedge OPB_CLK); #1;
    OPB_WE = 1'b0;
    if (a[31:8] == 24'h0) exp_wr++;
  endtask

  task automatic opb_read(input logic [31:0] a, output logic [31:0] d);
    @(negedge OPB_CLK);
    OPB_ADDR = a; OPB_RE = 1'b1;
    @(posedge OPB_CLK); #1;
    d = OPB_DI;
    OPB_RE = 1'b0;
    if (a[31:8] == 24'h0) exp_rd++;
  endtask

  task automatic pulses(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge OPB_CLK); PULSE_2KHZ = 1'b1;
      repeat (3) @(negedge OPB_CLK);
      PULSE_2KHZ = 1'b0;
      repeat (2) @(negedge OPB_CLK);
    end
  endtask

  task automatic test_reset;
    logic [31:0] d;
    OPB_RST = 1'b0; PULSE_2KHZ = 1'b1;
    repeat (3) @(posedge OPB_CLK);
    #1;
    n_checks++;
    if (OPB_DI !== 32'h0) begin n_fail++; $display("FAIL rst_di: got %h want 0", OPB_DI); end
    n_checks++;
    if (FIFO_NEMPTY !== 1'b0) begin n_fail++; $display("FAIL rst_nempty: got %b want 0", FIFO_NEMPTY); end
    @(negedge OPB_CLK); OPB_RST = 1'b1;
    // pulse already high at release must not count
    repeat (2) @(negedge OPB_CLK);
    PULSE_2KHZ = 1'b0;
    opb_read(32'h00, d);
    n_checks++;
    if (d !== 32'h0106_0973) begin n_fail++; $display("FAIL id: got %h want 01060973", d); end
    opb_read(32'h08, d);
    n_checks++;
    if (d !== 32'h1) begin n_fail++; $display("FAIL ctrl_rst: got %h want 00000001", d); end
    opb_read(32'h0C, d);
    n_checks++;
    if (d !== 32'h1) begin n_fail++; $display("FAIL status_rst: got %h want 00000001", d); end
  endtask

  task automatic test_scratch;
    logic [31:0] d;
    opb_write(32'h04, 32'hA5A5_5A5A);
    opb_read(32'h04, d);
    n_checks++;
    if (d !== 32'hA5A5_5A5A) begin n_fail++; $display("FAIL scratch: got %h want a5a55a5a", d); end
    opb_read(32'h1C, d);
    n_checks++;
    if (d !== 32'd4) begin n_fail++; $display("FAIL rd_cnt: got %0d want 4", d); end
    opb_read(32'h18, d);
    n_checks++;
    if (d !== 32'd1) begin n_fail++; $display("FAIL wr_cnt: got %0d want 1", d); end
  endtask

  task automatic test_fifo;
    logic [31:0] d;
    for (int i = 1; i <= 17; i++) opb_write(32'h14, i);
    n_checks++;
    if (FIFO_NEMPTY !== 1'b1) begin n_fail++; $display("FAIL nempty_full: got %b want 1", FIFO_NEMPTY); end
    opb_read(32'h0C, d);
    n_checks++;
    if (d !== 32'h0000_1006) begin n_fail++; $display("FAIL status_full: got %h want 00001006", d); end
    for (int i = 1; i <= 16; i++) begin
      opb_read(32'h14, d);
      n_checks++;
      if (d !== 32'(i)) begin n_fail++; $display("FAIL pop%0d: got %h want %h", i, d, i); end
    end
    opb_read(32'h14, d);
    n_checks++;
    if (d !== 32'h0) begin n_fail++; $display("FAIL pop_empty: got %h want 0", d); end
    n_checks++;
    if (FIFO_NEMPTY !== 1'b0) begin n_fail++; $display("FAIL nempty_empty: got %b want 0", FIFO_NEMPTY); end
    opb_read(32'h0C, d);
    n_checks++;
    if (d !== 32'h0000_0005) begin n_fail++; $display("FAIL status_empty: got %h want 00000005", d); end
    opb_write(32'h0C, 32'h4);
    opb_read(32'h0C, d);
    n_checks++;
    if (d !== 32'h0000_0001) begin n_fail++; $display("FAIL ovf_clr: got %h want 00000001", d); end
    // push then immediate read, then clear via CTRL keeping tick_en
    opb_write(32'h14, 32'hCAFE_0001);
    opb_read(32'h14, d);
    n_checks++;
    if (d !== 32'hCAFE_0001) begin n_fail++; $display("FAIL push_pop_b2b: got %h want cafe0001", d); end
    opb_write(32'h14, 32'h11);
    opb_write(32'h14, 32'h22);
    opb_write(32'h08, 32'h3);
    opb_read(32'h0C, d);
    n_checks++;
    if (d !== 32'h0000_0001) begin n_fail++; $display("FAIL fifo_clr: got %h want 00000001", d); end
  endtask

  task automatic test_tick;
    logic [31:0] d;
    opb_read(32'h10, d);
    n_checks++;
    if (d !== 32'h0) begin n_fail++; $display("FAIL tick_init: got %0d want 0", d); end
    pulses(5);
    opb_read(32'h10, d);
    n_checks++;
    if (d !== 32'd5) begin n_fail++; $display("FAIL tick5: got %0d want 5", d); end
    opb_write(32'h08, 32'h0);
    pulses(2);
    opb_read(32'h10, d);
    n_checks++;
    if (d !== 32'd5) begin n_fail++; $display("FAIL tick_dis: got %0d want 5", d); end
    opb_write(32'h08, 32'h5);
    opb_read(32'h10, d);
    n_checks++;
    if (d !== 32'h0) begin n_fail++; $display("FAIL tick_clr: got %0d want 0", d); end
    opb_read(32'h08, d);
    n_checks++;
    if (d !== 32'h1) begin n_fail++; $display("FAIL ctrl_en: got %h want 00000001", d); end
  endtask

  task automatic test_collision;
    logic [31:0] d;
    int rd_before;
    opb_read(32'h00, d);
    rd_before = exp_rd;
    @(negedge OPB_CLK);
    OPB_ADDR = 32'h14; OPB_DO = 32'h1234; OPB_RE = 1'b1; OPB_WE = 1'b1;
    @(posedge OPB_CLK); #1;
    OPB_RE = 1'b0; OPB_WE = 1'b0;
    exp_wr++;
    n_checks++;
    if (OPB_DI !== 32'h0106_0973) begin n_fail++; $display("FAIL coll_di: got %h want 01060973", OPB_DI); end
    opb_read(32'h0C, d);
    n_checks++;
    if (d !== 32'h0000_0100) begin n_fail++; $display("FAIL coll_level: got %h want 00000100", d); end
    opb_read(32'h1C, d);
    n_checks++;
    if (d !== 32'(rd_before + 1)) begin n_fail++; $display("FAIL coll_rdcnt: got %0d want %0d", d, rd_before + 1); end
  endtask

  task automatic test_window;
    logic [31:0] d;
    int wr_before;
    opb_read(32'h00, d);
    opb_read(32'h100, d);
    n_checks++;
    if (d !== 32'h0) begin n_fail++; $display("FAIL oow_rd: got %h want 0", d); end
    opb_write(32'h104, 32'hFFFF_FFFF);
    opb_read(32'h04, d);
    n_checks++;
    if (d !== 32'hA5A5_5A5A) begin n_fail++; $display("FAIL oow_wr: got %h want a5a55a5a", d); end
    opb_read(32'h1C, d);
    n_checks++;
    if (d !== 32'(exp_rd - 1)) begin n_fail++; $display("FAIL oow_rdcnt: got %0d want %0d", d, exp_rd - 1); end
    opb_read(32'h40, d);
    n_checks++;
    if (d !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL hole_rd: got %h want deadbeef", d); end
    wr_before = exp_wr;
    opb_write(32'h40, 32'h5555_5555);
    opb_read(32'h18, d);
    n_checks++;
    if (d !== 32'(wr_before + 1)) begin n_fail++; $display("FAIL hole_wrcnt: got %0d want %0d", d, wr_before + 1); end
    opb_read(32'h04, d);
    n_checks++;
    if (d !== 32'hA5A5_5A5A) begin n_fail++; $display("FAIL hole_noeff: got %h want a5a55a5a", d); end
  endtask

  initial begin
    test_reset;
    test_scratch;
    test_fifo;
    test_tick;
    test_collision;
    test_window;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
